// File: rtl/om_seq_ctrl.sv
// Iteration controller for the radix-2 online multiplier: sequences the
// online-delay INIT, RUN and FLUSH iterations and handshakes digits in and out.
module om_seq_ctrl #(
    parameter int N     = 8,
    parameter int DELTA = 2,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [1:0]    x_digit,
    input  logic [1:0]    y_digit,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1:0]    dp_x,
    output logic [1:0]    dp_y,
    output logic          dp_en,
    output logic          dp_clr,
    output logic [CW-1:0] dp_j,
    input  logic [1:0]    z_in,
    output logic [1:0]    z_out,
    output logic          z_valid,
    input  logic          z_ready,
    output logic          digit_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [CW-1:0] J_N        = CW'(N);
    localparam logic [CW-1:0] J_DELTA    = CW'(DELTA);
    localparam logic [CW-1:0] J_INIT_END = CW'(DELTA - 1);
    localparam logic [CW-1:0] J_RUN_END  = CW'(N - 1);
    localparam logic [CW-1:0] J_LAST     = CW'(N + DELTA - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] j, j_nxt;
    logic          active;
    logic          need_in;
    logic          need_out;
    logic          adv;
    logic          accept;
    logic          bad_digit;

    // Handshakes are purely combinational: in RUN the input and output
    // transfers complete together, so a stall on either side holds j.
    always_comb begin
        active    = (state != IDLE);
        need_in   = active && (j < J_N);
        need_out  = active && (j >= J_DELTA);
        adv       = active && (!need_in || in_valid) && (!need_out || z_ready);
        accept    = (state == IDLE) && start;
        bad_digit = (x_digit == 2'b11) || (y_digit == 2'b11);

        busy     = active;
        dp_en    = adv;
        dp_clr   = accept;
        dp_j     = j;
        in_ready = need_in && (!need_out || z_ready);
        z_valid  = need_out && (!need_in || in_valid);
        z_out    = need_out ? z_in : '0;
        dp_x     = need_in ? x_digit : '0;
        dp_y     = need_in ? y_digit : '0;
    end

    always_comb begin
        state_nxt = state;
        j_nxt     = j;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                    j_nxt     = '0;
                end
            end
            INIT: begin
                if (adv) begin
                    j_nxt = j + CW'(1);
                    if (j == J_INIT_END) state_nxt = RUN;
                end
            end
            RUN: begin
                if (adv) begin
                    j_nxt = j + CW'(1);
                    if (j == J_RUN_END) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (adv) begin
                    if (j == J_LAST) begin
                        state_nxt = IDLE;
                        j_nxt     = '0;
                    end else begin
                        j_nxt = j + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                j_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            j     <= '0;
        end else begin
            state <= state_nxt;
            j     <= j_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            digit_err <= 1'b0;
        end else begin
            done <= (state == FLUSH) && adv && (j == J_LAST);
            if (accept)
                digit_err <= 1'b0;
            else if (adv && need_in && bad_digit)
                digit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_om_seq_ctrl.sv
// Directed bench for om_seq_ctrl: cycle-by-cycle vector table plus
// hand-written reset, transfer-count and continuous-start sequences.
module tb_om_seq_ctrl;

    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] M = 2'b01;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] B = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, z_ready;
    logic [1:0] x_digit, y_digit, z_in;
    logic       busy, done, in_ready, dp_en, dp_clr, z_valid, digit_err;
    logic [1:0] dp_x, dp_y, z_out;
    logic [3:0] dp_j;

    int checks = 0;
    int errors = 0;

    om_seq_ctrl #(.N(8), .DELTA(2), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .x_digit(x_digit), .y_digit(y_digit), .in_valid(in_valid),
        .in_ready(in_ready), .dp_x(dp_x), .dp_y(dp_y), .dp_en(dp_en),
        .dp_clr(dp_clr), .dp_j(dp_j), .z_in(z_in), .z_out(z_out),
        .z_valid(z_valid), .z_ready(z_ready), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    // Output vector: {busy,in_ready,z_valid,dp_en,dp_clr,dp_j,dp_x,dp_y,z_out,done,digit_err}
    typedef struct packed {
        logic        start;
        logic        iv;
        logic [1:0]  x;
        logic [1:0]  y;
        logic        zr;
        logic [1:0]  zi;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic iv, input logic [1:0] x,
                                input logic [1:0] y, input logic zr, input logic [1:0] zi,
                                input logic bu, input logic ir, input logic zv, input logic en,
                                input logic cl, input int j, input logic [1:0] dx,
                                input logic [1:0] dy, input logic [1:0] zo, input logic dn,
                                input logic er);
        vec_t v;
        logic [3:0] jj;
        jj = 4'(j);
        v.start = st; v.iv = iv; v.x = x; v.y = y; v.zr = zr; v.zi = zi;
        v.exp = {bu, ir, zv, en, cl, jj, dx, dy, zo, dn, er};
        vecs.push_back(v);
    endfunction

    function automatic logic [16:0] outs();
        return {busy, in_ready, z_valid, dp_en, dp_clr, dp_j, dp_x, dp_y, z_out, done, digit_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    int n_en, n_in, n_out, done_seen;
    logic [16:0] expv;

    initial begin
        rst_n = 1'b0; start = 0; in_valid = 0; z_ready = 0;
        x_digit = Z; y_digit = Z; z_in = Z;

        // cycle-by-cycle vectors: (start,iv,x,y,zr,zi, busy,ir,zv,en,clr,j,dx,dy,zo,done,err)
        // full run with a start pulse ignored at j=4
        add(1,1,Z,Z,1,Z, 0,0,0,0,1,0,Z,Z,Z,0,0);
        add(0,1,P,P,1,M, 1,1,0,1,0,0,P,P,Z,0,0);
        add(0,1,M,P,1,M, 1,1,0,1,0,1,M,P,Z,0,0);
        add(0,1,Z,P,1,P, 1,1,1,1,0,2,Z,P,P,0,0);
        add(0,1,P,P,1,M, 1,1,1,1,0,3,P,P,M,0,0);
        add(1,1,M,P,1,P, 1,1,1,1,0,4,M,P,P,0,0);
        add(0,1,P,P,1,Z, 1,1,1,1,0,5,P,P,Z,0,0);
        add(0,1,Z,P,1,M, 1,1,1,1,0,6,Z,P,M,0,0);
        add(0,1,M,P,1,P, 1,1,1,1,0,7,M,P,P,0,0);
        add(0,0,P,P,1,M, 1,0,1,1,0,8,Z,Z,M,0,0);
        add(0,0,P,P,1,P, 1,0,1,1,0,9,Z,Z,P,0,0);
        add(0,0,Z,Z,1,Z, 0,0,0,0,0,0,Z,Z,Z,1,0);
        add(0,1,P,P,1,P, 0,0,0,0,0,0,Z,Z,Z,0,0);
        // downstream back-pressure in INIT, RUN and FLUSH
        add(1,1,P,P,1,Z, 0,0,0,0,1,0,Z,Z,Z,0,0);
        add(0,1,P,P,1,Z, 1,1,0,1,0,0,P,P,Z,0,0);
        add(0,1,M,M,0,Z, 1,1,0,1,0,1,M,M,Z,0,0);
        add(0,1,P,M,1,P, 1,1,1,1,0,2,P,M,P,0,0);
        add(0,1,Z,P,1,M, 1,1,1,1,0,3,Z,P,M,0,0);
        add(0,1,M,M,0,P, 1,0,1,0,0,4,M,M,P,0,0);
        add(0,1,M,M,0,P, 1,0,1,0,0,4,M,M,P,0,0);
        add(0,1,M,M,0,P, 1,0,1,0,0,4,M,M,P,0,0);
        add(0,1,M,M,1,P, 1,1,1,1,0,4,M,M,P,0,0);
        add(0,1,P,P,1,M, 1,1,1,1,0,5,P,P,M,0,0);
        add(0,1,M,Z,1,P, 1,1,1,1,0,6,M,Z,P,0,0);
        add(0,1,Z,M,1,M, 1,1,1,1,0,7,Z,M,M,0,0);
        add(0,1,P,P,0,P, 1,0,1,0,0,8,Z,Z,P,0,0);
        add(0,1,P,P,1,P, 1,0,1,1,0,8,Z,Z,P,0,0);
        add(0,1,P,P,1,M, 1,0,1,1,0,9,Z,Z,M,0,0);
        add(0,1,P,P,1,Z, 0,0,0,0,0,0,Z,Z,Z,1,0);
        // upstream bubbles and illegal digits (only accepted ones are flagged)
        add(1,1,Z,Z,1,Z, 0,0,0,0,1,0,Z,Z,Z,0,0);
        add(0,0,P,P,1,Z, 1,1,0,0,0,0,P,P,Z,0,0);
        add(0,1,P,P,1,Z, 1,1,0,1,0,0,P,P,Z,0,0);
        add(0,1,M,M,1,Z, 1,1,0,1,0,1,M,M,Z,0,0);
        add(0,0,B,Z,1,P, 1,1,0,0,0,2,B,Z,P,0,0);
        add(0,1,P,P,1,P, 1,1,1,1,0,2,P,P,P,0,0);
        add(0,1,B,P,1,M, 1,1,1,1,0,3,B,P,M,0,0);
        add(0,0,M,M,1,M, 1,1,0,0,0,4,M,M,M,0,1);
        add(0,1,M,M,1,M, 1,1,1,1,0,4,M,M,M,0,1);
        add(0,0,P,P,1,P, 1,1,0,0,0,5,P,P,P,0,1);
        add(0,1,P,P,1,P, 1,1,1,1,0,5,P,P,P,0,1);
        add(0,0,Z,Z,1,M, 1,1,0,0,0,6,Z,Z,M,0,1);
        add(0,1,Z,Z,1,M, 1,1,1,1,0,6,Z,Z,M,0,1);
        add(0,1,M,P,1,P, 1,1,1,1,0,7,M,P,P,0,1);
        add(0,0,B,B,1,M, 1,0,1,1,0,8,Z,Z,M,0,1);
        add(0,0,Z,Z,1,P, 1,0,1,1,0,9,Z,Z,P,0,1);
        add(0,0,Z,Z,1,Z, 0,0,0,0,0,0,Z,Z,Z,1,1);
        add(1,0,Z,Z,1,Z, 0,0,0,0,1,0,Z,Z,Z,0,1);
        add(0,0,P,P,1,Z, 1,1,0,0,0,0,P,P,Z,0,0);

        // reset state
        #3;
        chk("reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start; in_valid = vecs[i].iv;
            x_digit = vecs[i].x; y_digit = vecs[i].y;
            z_ready = vecs[i].zr; z_in = vecs[i].zi;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 0; rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        start = 1; in_valid = 1; z_ready = 1; x_digit = P; y_digit = P; z_in = M;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 20 && !(busy && dp_j == 4'd5); k++) @(negedge clk);
        chk("reach_j5", 32'({busy, dp_j}), 32'({1'b1, 4'd5}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_after_reset", 32'(outs()), 32'd0);

        // fresh run with input bubbles: transfer and enable totals
        @(negedge clk);
        start = 1;
        #1;
        chk("restart_clr", 32'({busy, dp_clr}), 32'({1'b0, 1'b1}));
        n_en = 0; n_in = 0; n_out = 0; done_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 0;
            in_valid = (k % 2) == 1;
            #1;
            if (dp_en) n_en++;
            if (in_ready && in_valid) n_in++;
            if (z_valid && z_ready) n_out++;
            if (done) begin
                done_seen = 1;
                break;
            end
        end
        chk("done_within_budget", 32'(done_seen), 32'd1);
        chk("dp_en_total", 32'(n_en), 32'd10);
        chk("in_transfers", 32'(n_in), 32'd8);
        chk("out_transfers", 32'(n_out), 32'd8);

        // start held high: restart in every done cycle, ignored while busy
        start = 1; in_valid = 1;
        for (int c = 0; c <= 33; c++) begin
            int p;
            if (c > 0) begin
                @(negedge clk);
                #1;
            end else begin
                #0;
            end
            p = c % 11;
            expv = {(p != 0), 1'b0, 1'b0, 1'b0, (p == 0), ((p == 0) ? 4'd0 : 4'(p - 1)),
                    2'b00, 2'b00, 2'b00, (p == 0), 1'b0};
            chk($sformatf("held_start_c%0d", c),
                32'({busy, 3'b000, dp_clr, dp_j, 6'd0, done, digit_err}), 32'(expv));
        end
        start = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
